// File: rtl/cpu_exec_if.sv
// Instruction handshake and status bundle for cpu_exec_core.
// The master is the instruction source; the slave is the core.
interface cpu_exec_if #(
    parameter int REG_WIDTH = 16
);
    logic                 instr_valid_i;
    logic                 instr_ready_o;
    logic [15:0]          instr_i;
    logic                 done_o;
    logic                 err_o;
    logic [REG_WIDTH-1:0] result_o;
    logic                 carry_o;
    logic                 zero_o;

    modport master (
        output instr_valid_i, instr_i,
        input  instr_ready_o, done_o, err_o, result_o, carry_o, zero_o
    );

    modport slave (
        input  instr_valid_i, instr_i,
        output instr_ready_o, done_o, err_o, result_o, carry_o, zero_o
    );
endinterface

// File: rtl/cpu_exec_core.sv
// Multi-cycle execution core: register file, ALU, C/Z flags, IDLE/EXEC/WB sequencer.
// Optional debug read port enabled by defining CPU_EXEC_CORE_DBG_EN.
module cpu_exec_core #(
    parameter int REG_WIDTH = 16,
    parameter int NUM_REGS  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cpu_exec_if.slave            bus
`ifdef CPU_EXEC_CORE_DBG_EN
    ,
    input  logic [3:0]           dbg_addr_i,
    output logic [REG_WIDTH-1:0] dbg_data_o
`endif
);
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_ADC = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_SBC = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_MOV = 4'hB;
    localparam logic [3:0] OP_LDI = 4'hC;
    localparam logic [3:0] OP_CMP = 4'hD;
    localparam logic [4:0] NR     = 5'(NUM_REGS);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t               state;
    logic [15:0]          ir;
    logic [REG_WIDTH-1:0] regs [NUM_REGS];
    logic [3:0]           op, rd, ra, rb;
    logic [REG_WIDTH-1:0] a, b, bx, alu_res;
    logic [REG_WIDTH:0]   sum;
    logic                 cin, alu_c, wr_en, c_en, z_en, illegal;
    logic                 p_wr, p_c_en, p_z_en, p_c, p_z;

    assign op = ir[15:12];
    assign rd = ir[11:8];
    assign ra = ir[7:4];
    assign rb = ir[3:0];

    // Operand fetch; out-of-range indices read as zero (and are flagged illegal).
    always_comb begin
        a = '0;
        b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ra == 4'(i)) a = regs[i];
            if (rb == 4'(i)) b = regs[i];
        end
    end

    // Illegal: reserved opcode or a referenced register beyond the file.
    always_comb begin
        illegal = 1'b0;
        if (op == 4'hE || op == 4'hF)
            illegal = 1'b1;
        else if (op == OP_LDI)
            illegal = ({1'b0, rd} >= NR);
        else if (op != OP_NOP)
            illegal = ({1'b0, rd} >= NR) || ({1'b0, ra} >= NR)
                   || ({1'b0, rb} >= NR);
    end

    // ALU: one shared adder serves ADD/ADC/SUB/SBC/CMP via operand inversion.
    always_comb begin
        bx  = (op == OP_SUB || op == OP_SBC || op == OP_CMP) ? ~b : b;
        cin = 1'b0;
        if (op == OP_ADC || op == OP_SBC) cin = bus.carry_o;
        if (op == OP_SUB || op == OP_CMP) cin = 1'b1;
        sum = {1'b0, a} + {1'b0, bx} + {{REG_WIDTH{1'b0}}, cin};
        alu_res = '0;
        alu_c   = bus.carry_o;
        wr_en   = 1'b0;
        c_en    = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                alu_res = sum[REG_WIDTH-1:0];
                alu_c   = sum[REG_WIDTH];
                c_en    = 1'b1;
                wr_en   = 1'b1;
            end
            OP_CMP: begin
                alu_res = sum[REG_WIDTH-1:0];
                alu_c   = sum[REG_WIDTH];
                c_en    = 1'b1;
            end
            OP_AND: begin alu_res = a & b; wr_en = 1'b1; end
            OP_OR:  begin alu_res = a | b; wr_en = 1'b1; end
            OP_XOR: begin alu_res = a ^ b; wr_en = 1'b1; end
            OP_NOT: begin alu_res = ~a;    wr_en = 1'b1; end
            OP_SHL: begin
                alu_res = {a[REG_WIDTH-2:0], 1'b0};
                alu_c   = a[REG_WIDTH-1];
                c_en    = 1'b1;
                wr_en   = 1'b1;
            end
            OP_SHR: begin
                alu_res = {1'b0, a[REG_WIDTH-1:1]};
                alu_c   = a[0];
                c_en    = 1'b1;
                wr_en   = 1'b1;
            end
            OP_MOV: begin alu_res = a; wr_en = 1'b1; end
            OP_LDI: begin alu_res = REG_WIDTH'(ir[7:0]); wr_en = 1'b1; end
            default: ;
        endcase
        z_en = wr_en || (op == OP_CMP);
    end

    // Sequencer: accept in IDLE, compute in EXEC, commit in WB.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            ir                <= '0;
            bus.instr_ready_o <= 1'b1;
            bus.done_o        <= 1'b0;
            bus.err_o         <= 1'b0;
            bus.result_o      <= '0;
            bus.carry_o       <= 1'b0;
            bus.zero_o        <= 1'b0;
            p_wr              <= 1'b0;
            p_c_en            <= 1'b0;
            p_z_en            <= 1'b0;
            p_c               <= 1'b0;
            p_z               <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid_i) begin
                        ir                <= bus.instr_i;
                        bus.instr_ready_o <= 1'b0;
                        state             <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    bus.result_o <= illegal ? '0 : alu_res;
                    bus.err_o    <= illegal;
                    bus.done_o   <= 1'b1;
                    p_wr         <= wr_en && !illegal;
                    p_c_en       <= c_en && !illegal;
                    p_z_en       <= z_en && !illegal;
                    p_c          <= alu_c;
                    p_z          <= (alu_res == '0);
                    state        <= S_WB;
                end
                S_WB: begin
                    for (int i = 0; i < NUM_REGS; i++)
                        if (p_wr && rd == 4'(i)) regs[i] <= bus.result_o;
                    if (p_c_en) bus.carry_o <= p_c;
                    if (p_z_en) bus.zero_o  <= p_z;
                    bus.done_o        <= 1'b0;
                    bus.err_o         <= 1'b0;
                    bus.instr_ready_o <= 1'b1;
                    state             <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CPU_EXEC_CORE_DBG_EN
    // Debug read port, side-effect free.
    always_comb begin
        dbg_data_o = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (dbg_addr_i == 4'(i)) dbg_data_o = regs[i];
    end
`endif
endmodule

// File: tb/tb_cpu_exec_core.sv
// Self-checking bench for cpu_exec_core: directed scenarios plus random
// instruction streams compared against an arithmetic reference model.
module tb_cpu_exec_core;
    localparam int W = 16;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    cpu_exec_if #(.REG_WIDTH(W)) bus ();

`ifdef CPU_EXEC_CORE_DBG_EN
    logic [3:0]   dbg_addr = 4'd0;
    logic [W-1:0] dbg_data;
`endif

    cpu_exec_core #(.REG_WIDTH(W), .NUM_REGS(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef CPU_EXEC_CORE_DBG_EN
        ,
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
`endif
    );

    int checks = 0;
    int failures = 0;

    logic [W-1:0] m_r [16];
    bit           m_c;
    bit           m_z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] enc(input int op, input int rd, input int ra, input int rb);
        return {4'(op), 4'(rd), 4'(ra), 4'(rb)};
    endfunction

    function automatic logic [15:0] ldi(input int rd, input int imm);
        return {4'hC, 4'(rd), 8'(imm)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_c = 1'b0;
        m_z = 1'b0;
    endfunction

    // Reference: values as plain integers, modulo 2^W.
    function automatic void model(input logic [15:0] ins, output bit err, output logic [W-1:0] res);
        int op, rd, ra, rb;
        longint a, b, s, mx;
        op = int'(ins[15:12]);
        rd = int'(ins[11:8]);
        ra = int'(ins[7:4]);
        rb = int'(ins[3:0]);
        mx = (longint'(1) << W) - 1;
        err = 1'b0;
        res = '0;
        if (op >= 14) err = 1'b1;
        else if (op == 12) err = (rd >= N);
        else if (op != 0) err = (rd >= N) || (ra >= N) || (rb >= N);
        if (err || op == 0) return;
        a = longint'(m_r[ra]);
        b = longint'(m_r[rb]);
        case (op)
            1: s = a + b;
            2: s = a + b + longint'(m_c);
            3, 13: s = a + (mx - b) + 1;
            4: s = a + (mx - b) + longint'(m_c);
            5: s = a & b;
            6: s = a | b;
            7: s = a ^ b;
            8: s = mx - a;
            9: s = a * 2;
            10: s = a / 2;
            11: s = a;
            12: s = longint'(ins[7:0]);
            default: s = 0;
        endcase
        res = W'(s & mx);
        if ((op >= 1 && op <= 4) || op == 13) m_c = (s > mx);
        if (op == 9) m_c = (a > mx / 2);
        if (op == 10) m_c = (a % 2 == 1);
        m_z = (res == '0);
        if (op != 13) m_r[rd] = res;
    endfunction

    // Issue one instruction; starts and ends just after a falling edge.
    task automatic exec(input logic [15:0] ins, input string tag);
        bit e;
        logic [W-1:0] r;
        int n;
        model(ins, e, r);
        n = 0;
        while (bus.instr_ready_o !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ":ready_idle"}, 32'(bus.instr_ready_o), 1);
        bus.instr_valid_i = 1'b1;
        bus.instr_i = ins;
        @(negedge clk);
        bus.instr_valid_i = 1'b0;
        chk({tag, ":ready_exec"}, 32'(bus.instr_ready_o), 0);
        chk({tag, ":done_exec"}, 32'(bus.done_o), 0);
        @(negedge clk);
        chk({tag, ":done_wb"}, 32'(bus.done_o), 1);
        chk({tag, ":err_wb"}, 32'(bus.err_o), 32'(e));
        if (ins[15:12] != 4'h0)
            chk({tag, ":result"}, 32'(bus.result_o), 32'(r));
        @(negedge clk);
        chk({tag, ":done_after"}, 32'(bus.done_o), 0);
        chk({tag, ":err_after"}, 32'(bus.err_o), 0);
        chk({tag, ":carry"}, 32'(bus.carry_o), 32'(m_c));
        chk({tag, ":zero"}, 32'(bus.zero_o), 32'(m_z));
    endtask

    task automatic read_reg(input int i, input string tag);
`ifdef CPU_EXEC_CORE_DBG_EN
        dbg_addr = 4'(i);
        #1;
        chk({tag, ":dbg"}, 32'(dbg_data), 32'(m_r[i]));
`else
        exec(enc(6, i, i, i), {tag, ":rd_or"});
`endif
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < N; i++) read_reg(i, $sformatf("%s_r%0d", tag, i));
    endtask

    initial begin
        logic [15:0] lst [3];
        logic [15:0] ins;
        bit e;
        logic [W-1:0] r;
        int op;

        bus.instr_valid_i = 1'b0;
        bus.instr_i = '0;
        model_reset();

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(bus.instr_ready_o), 1);
        chk("rst_done", 32'(bus.done_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_carry", 32'(bus.carry_o), 0);
        chk("rst_zero", 32'(bus.zero_o), 0);
        chk("rst_result", 32'(bus.result_o), 0);
`ifdef CPU_EXEC_CORE_DBG_EN
        read_all("rst");
        dbg_addr = 4'd12;
        #1;
        chk("dbg_oob", 32'(dbg_data), 0);
`endif

        // Carry wrap
        exec(ldi(1, 8'h00), "cw_ldi1");
        exec(enc(8, 1, 1, 1), "cw_not");
        chk("cw_not_val", 32'(bus.result_o), 32'hFFFF);
        exec(ldi(2, 8'h01), "cw_ldi2");
        exec(enc(1, 3, 1, 2), "cw_add");
        chk("cw_add_val", 32'(bus.result_o), 0);
        chk("cw_add_c", 32'(bus.carry_o), 1);
        chk("cw_add_z", 32'(bus.zero_o), 1);
        exec(enc(2, 4, 2, 2), "cw_adc");
        chk("cw_adc_val", 32'(bus.result_o), 3);
        chk("cw_adc_c", 32'(bus.carry_o), 0);
        read_all("cw");

        // Borrow and compare
        exec(ldi(1, 5), "bw_ldi1");
        exec(ldi(2, 7), "bw_ldi2");
        exec(enc(3, 3, 1, 2), "bw_sub");
        chk("bw_sub_val", 32'(bus.result_o), 32'hFFFE);
        chk("bw_sub_c", 32'(bus.carry_o), 0);
        chk("bw_sub_z", 32'(bus.zero_o), 0);
        exec(enc(13, 0, 2, 2), "bw_cmp");
        chk("bw_cmp_val", 32'(bus.result_o), 0);
        chk("bw_cmp_c", 32'(bus.carry_o), 1);
        chk("bw_cmp_z", 32'(bus.zero_o), 1);
        read_all("bw");

        // Back-to-back with valid held high
        lst[0] = ldi(5, 8'h11);
        lst[1] = ldi(6, 8'h22);
        lst[2] = ldi(7, 8'h33);
        bus.instr_valid_i = 1'b1;
        bus.instr_i = lst[0];
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_%0d", k), 32'(bus.instr_ready_o), 32'(k % 3 == 2));
            chk($sformatf("b2b_done_%0d", k), 32'(bus.done_o), 32'(k % 3 == 1));
            if (k % 3 == 1) begin
                model(lst[k / 3], e, r);
                chk($sformatf("b2b_res_%0d", k), 32'(bus.result_o), 32'(r));
            end
            if (k % 3 == 2 && k < 8) bus.instr_i = lst[k / 3 + 1];
            if (k == 8) bus.instr_valid_i = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle_done", 32'(bus.done_o), 0);
        read_all("b2b");

        // Illegal instructions
        exec(ldi(9, 8'h12), "il_ldi");
        exec(16'hE123, "il_resv");
        exec(enc(1, 1, 2, 10), "il_add");
        chk("il_add_res", 32'(bus.result_o), 0);
        read_all("il");

        // Reset during EXEC
        exec(ldi(1, 8'h40), "rm_ldi1");
        exec(ldi(2, 8'h02), "rm_ldi2");
        bus.instr_valid_i = 1'b1;
        bus.instr_i = enc(1, 3, 1, 2);
        @(negedge clk);
        bus.instr_valid_i = 1'b0;
        chk("rm_in_exec", 32'(bus.instr_ready_o), 0);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rm_no_done", 32'(bus.done_o), 0);
        reset_n = 1'b1;
        @(negedge clk);
        model_reset();
        chk("rm_ready", 32'(bus.instr_ready_o), 1);
        chk("rm_done", 32'(bus.done_o), 0);
        chk("rm_result", 32'(bus.result_o), 0);
        read_reg(3, "rm");

        // Random streams against the model
        for (int i = 0; i < N; i++)
            exec(ldi(i, $urandom_range(0, 255)), $sformatf("seed_%0d", i));
        for (int k = 0; k < 160; k++) begin
            op = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0)
                ins = {4'(op), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15))};
            else
                ins = {4'(op), 4'($urandom_range(0, N - 1)), 4'($urandom_range(0, N - 1)),
                       4'($urandom_range(0, N - 1))};
            exec(ins, $sformatf("rnd_%0d_%h", k, ins));
        end
        read_all("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
